// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match controller: state codes, key bytes,
// winner encoding and the saturating score increment.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_PLAY       = 3'd2,
        ST_PAUSE      = 3'd3,
        ST_POINT      = 3'd4,
        ST_GAME_OVER  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_t;

    localparam logic [7:0] START_KEY   = 8'd103;  // 'g'
    localparam logic [7:0] RESTART_KEY = 8'd98;   // 'b'
    localparam logic [7:0] PAUSE_KEY   = 8'd112;  // 'p'

    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/pong_edge_detect.sv
// Rising-edge detector for a ball-block score flag; history updates every cycle
// so a flag held high across states produces only one edge.
module pong_edge_detect (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_sig,
    output logic o_rise
);

    logic prev;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) prev <= 1'b0;
        else       prev <= i_sig;
    end

    assign o_rise = i_sig & ~prev;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: key decoding, serve pacing, scoring and game-over detection
// driving the ball block's run/recenter/serve controls.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic [7:0] i_key_byte,
    input  logic       i_key_dv,
    input  logic       i_frame_tick,
    input  logic       i_p1_scored,
    input  logic       i_p2_scored,
    output logic       o_ball_run,
    output logic       o_ball_recenter,
    output logic       o_serve,
    output logic       o_serve_dir,
    output logic [3:0] o_p1_score,
    output logic [3:0] o_p2_score,
    output logic [1:0] o_winner,
    output logic [2:0] o_state
);

    localparam logic [3:0] WIN_LIMIT  = WIN_SCORE[3:0];
    localparam logic [7:0] SERVE_LOAD = SERVE_FRAMES[7:0];

    state_t     state, state_n;
    winner_t    scorer, scorer_n, winner, winner_n;
    logic [7:0] serve_cnt, serve_cnt_n;
    logic       tick_armed, tick_armed_n;
    logic [3:0] p1_score, p1_score_n, p2_score, p2_score_n, bumped;
    logic       serve_dir, serve_dir_n;
    logic       recenter, recenter_n, serve, serve_n, ball_run;
    logic       p1_rise, p2_rise;

    pong_edge_detect u_p1_edge (.i_CLK(i_CLK), .i_RST(i_RST), .i_sig(i_p1_scored), .o_rise(p1_rise));
    pong_edge_detect u_p2_edge (.i_CLK(i_CLK), .i_RST(i_RST), .i_sig(i_p2_scored), .o_rise(p2_rise));

    wire key_start   = i_key_dv && (i_key_byte == START_KEY);
    wire key_restart = i_key_dv && (i_key_byte == RESTART_KEY);
    wire key_pause   = i_key_dv && (i_key_byte == PAUSE_KEY);

    assign bumped = sat_inc((scorer == WIN_P1) ? p1_score : p2_score, WIN_LIMIT);

    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        state_n      = state;
        scorer_n     = scorer;
        winner_n     = winner;
        serve_cnt_n  = serve_cnt;
        tick_armed_n = tick_armed;
        p1_score_n   = p1_score;
        p2_score_n   = p2_score;
        serve_dir_n  = serve_dir;
        recenter_n   = 1'b0;
        serve_n      = 1'b0;

        if (key_restart) begin
            state_n     = ST_IDLE;
            p1_score_n  = 4'd0;
            p2_score_n  = 4'd0;
            winner_n    = WIN_NONE;
            serve_cnt_n = 8'd0;
            serve_dir_n = 1'b0;
            recenter_n  = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE, ST_GAME_OVER: if (key_start) begin
                    state_n      = ST_SERVE_WAIT;
                    p1_score_n   = 4'd0;
                    p2_score_n   = 4'd0;
                    winner_n     = WIN_NONE;
                    serve_cnt_n  = SERVE_LOAD;
                    tick_armed_n = 1'b0;
                    recenter_n   = 1'b1;
                end
                ST_SERVE_WAIT: begin
                    // Ticks count only from the second cycle in SERVE_WAIT onward.
                    tick_armed_n = 1'b1;
                    if (serve_cnt == 8'd0) begin
                        state_n = ST_PLAY;
                        serve_n = 1'b1;
                    end else if (i_frame_tick && tick_armed) begin
                        serve_cnt_n = serve_cnt - 8'd1;
                        if (serve_cnt == 8'd1) begin
                            state_n = ST_PLAY;
                            serve_n = 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (p1_rise && p2_rise) begin
                        state_n      = ST_SERVE_WAIT;
                        serve_cnt_n  = SERVE_LOAD;
                        tick_armed_n = 1'b0;
                        recenter_n   = 1'b1;
                    end else if (p1_rise) begin
                        state_n  = ST_POINT;
                        scorer_n = WIN_P1;
                    end else if (p2_rise) begin
                        state_n  = ST_POINT;
                        scorer_n = WIN_P2;
                    end else if (key_pause) begin
                        state_n = ST_PAUSE;
                    end
                end
                ST_PAUSE: if (key_pause) state_n = ST_PLAY;
                ST_POINT: begin
                    recenter_n = 1'b1;
                    if (scorer == WIN_P1) begin
                        p1_score_n  = bumped;
                        serve_dir_n = 1'b1;
                    end else begin
                        p2_score_n  = bumped;
                        serve_dir_n = 1'b0;
                    end
                    if (bumped == WIN_LIMIT) begin
                        state_n  = ST_GAME_OVER;
                        winner_n = scorer;
                    end else begin
                        state_n      = ST_SERVE_WAIT;
                        serve_cnt_n  = SERVE_LOAD;
                        tick_armed_n = 1'b0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state      <= ST_IDLE;
            scorer     <= WIN_NONE;
            winner     <= WIN_NONE;
            serve_cnt  <= 8'd0;
            tick_armed <= 1'b0;
            p1_score   <= 4'd0;
            p2_score   <= 4'd0;
            serve_dir  <= 1'b0;
            recenter   <= 1'b0;
            serve      <= 1'b0;
            ball_run   <= 1'b0;
        end else begin
            state      <= state_n;
            scorer     <= scorer_n;
            winner     <= winner_n;
            serve_cnt  <= serve_cnt_n;
            tick_armed <= tick_armed_n;
            p1_score   <= p1_score_n;
            p2_score   <= p2_score_n;
            serve_dir  <= serve_dir_n;
            recenter   <= recenter_n;
            serve      <= serve_n;
            ball_run   <= (state_n == ST_PLAY);
        end
    end

    assign o_state         = state;
    assign o_winner        = winner;
    assign o_p1_score      = p1_score;
    assign o_p2_score      = p2_score;
    assign o_serve_dir     = serve_dir;
    assign o_ball_recenter = recenter;
    assign o_serve         = serve;
    assign o_ball_run      = ball_run;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl with SERVE_FRAMES=3, WIN_SCORE=7.
module tb_pong_match_ctrl;
    import pong_pkg::*;

    logic       i_CLK, i_RST;
    logic [7:0] i_key_byte;
    logic       i_key_dv, i_frame_tick, i_p1_scored, i_p2_scored;
    logic       o_ball_run, o_ball_recenter, o_serve, o_serve_dir;
    logic [3:0] o_p1_score, o_p2_score;
    logic [1:0] o_winner;
    logic [2:0] o_state;

    typedef struct {
        string       tag;
        logic [16:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    pong_match_ctrl #(.WIN_SCORE(7), .SERVE_FRAMES(3)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_key_byte(i_key_byte), .i_key_dv(i_key_dv),
        .i_frame_tick(i_frame_tick), .i_p1_scored(i_p1_scored), .i_p2_scored(i_p2_scored),
        .o_ball_run(o_ball_run), .o_ball_recenter(o_ball_recenter), .o_serve(o_serve),
        .o_serve_dir(o_serve_dir), .o_p1_score(o_p1_score), .o_p2_score(o_p2_score),
        .o_winner(o_winner), .o_state(o_state)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    // Snapshot layout: state, p1, p2, winner, run, dir, recenter, serve.
    function automatic logic [16:0] mk(state_t s, logic [3:0] a, logic [3:0] b, logic [1:0] w,
                                       logic run, logic dir, logic rc, logic sv);
        return {s, a, b, w, run, dir, rc, sv};
    endfunction

    function automatic logic [16:0] obs();
        return {o_state, o_p1_score, o_p2_score, o_winner, o_ball_run, o_serve_dir, o_ball_recenter, o_serve};
    endfunction

    task automatic expect_next(input string tag, input logic [16:0] v);
        sb.push_back('{tag, v});
    endtask

    // Drive one clock's worth of strobes; returns at the following negedge.
    task automatic step(input logic dv, input logic [7:0] kb, input logic tk);
        i_key_dv = dv; i_key_byte = kb; i_frame_tick = tk;
        @(negedge i_CLK);
        i_key_dv = 1'b0; i_key_byte = 8'd0; i_frame_tick = 1'b0;
    endtask

    task automatic serve_check(input string tag, input logic [3:0] a, input logic [3:0] b, input logic dir);
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        expect_next(tag, mk(ST_PLAY, a, b, WIN_NONE, 1'b1, dir, 1'b0, 1'b1));
        step(1'b0, 8'd0, 1'b1);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
    endtask

    task automatic score_point(input logic p1);
        if (p1) i_p1_scored = 1'b1; else i_p2_scored = 1'b1;
        step(1'b0, 8'd0, 1'b0);
        i_p1_scored = 1'b0; i_p2_scored = 1'b0;
        step(1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_reset();
        i_RST = 1'b1; i_key_dv = 1'b0; i_key_byte = 8'd0; i_frame_tick = 1'b0;
        i_p1_scored = 1'b0; i_p2_scored = 1'b0;
        expect_next("reset_held", 17'd0);
        @(negedge i_CLK);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        i_RST = 1'b0;
        expect_next("reset_released", mk(ST_IDLE, 0, 0, WIN_NONE, 0, 0, 0, 0));
        step(1'b0, 8'd0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
    endtask

    task automatic test_serve();
        // Tick coincident with the start key must not count.
        expect_next("start_key", mk(ST_SERVE_WAIT, 0, 0, WIN_NONE, 0, 0, 1, 0));
        step(1'b1, START_KEY, 1'b1);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        expect_next("serve_wait_after_2_ticks", mk(ST_SERVE_WAIT, 0, 0, WIN_NONE, 0, 0, 0, 0));
        step(1'b0, 8'd0, 1'b1);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        expect_next("serve_after_3rd_tick", mk(ST_PLAY, 0, 0, WIN_NONE, 1, 0, 0, 1));
        step(1'b0, 8'd0, 1'b1);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        expect_next("play_steady", mk(ST_PLAY, 0, 0, WIN_NONE, 1, 0, 0, 0));
        step(1'b0, 8'd0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
    endtask

    task automatic test_p2_hold();
        i_p2_scored = 1'b1;
        expect_next("p2_point_state", mk(ST_POINT, 0, 0, WIN_NONE, 0, 0, 0, 0));
        step(1'b0, 8'd0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        expect_next("p2_scored", mk(ST_SERVE_WAIT, 0, 1, WIN_NONE, 0, 0, 1, 0));
        step(1'b0, 8'd0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        serve_check("p2_hold_serve", 0, 1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'd0, 1'b0);
        expect_next("p2_held_no_double", mk(ST_PLAY, 0, 1, WIN_NONE, 1, 0, 0, 0));
        step(1'b0, 8'd0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        i_p2_scored = 1'b0;
        step(1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_pause();
        expect_next("pause_enter", mk(ST_PAUSE, 0, 1, WIN_NONE, 0, 0, 0, 0));
        step(1'b1, PAUSE_KEY, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        i_p1_scored = 1'b1;
        step(1'b0, 8'd0, 1'b0);
        i_p1_scored = 1'b0;
        expect_next("pause_discards_edge", mk(ST_PAUSE, 0, 1, WIN_NONE, 0, 0, 0, 0));
        step(1'b0, 8'd0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        expect_next("pause_resume", mk(ST_PLAY, 0, 1, WIN_NONE, 1, 0, 0, 0));
        step(1'b1, PAUSE_KEY, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        // Score edge and pause key together: the score wins.
        i_p1_scored = 1'b1;
        expect_next("score_beats_pause", mk(ST_POINT, 0, 1, WIN_NONE, 0, 0, 0, 0));
        step(1'b1, PAUSE_KEY, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        i_p1_scored = 1'b0;
        expect_next("p1_scored_dir_left", mk(ST_SERVE_WAIT, 1, 1, WIN_NONE, 0, 1, 1, 0));
        step(1'b0, 8'd0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        serve_check("serve_left", 1, 1, 1'b1);
    endtask

    task automatic test_both();
        i_p1_scored = 1'b1; i_p2_scored = 1'b1;
        expect_next("both_edges_no_point", mk(ST_SERVE_WAIT, 1, 1, WIN_NONE, 0, 1, 1, 0));
        step(1'b0, 8'd0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        i_p1_scored = 1'b0; i_p2_scored = 1'b0;
        serve_check("both_edges_reserve", 1, 1, 1'b1);
    endtask

    task automatic test_win();
        for (int k = 2; k <= 7; k++) begin
            if (k < 7) expect_next("p1_point", mk(ST_SERVE_WAIT, 4'(k), 1, WIN_NONE, 0, 1, 1, 0));
            else       expect_next("p1_wins",  mk(ST_GAME_OVER, 7, 1, WIN_P1, 0, 1, 1, 0));
            score_point(1'b1);
            e = sb.pop_front(); n_checks++;
            if (obs() !== e.v) $display("FAIL %s(%0d): got %h, expected %h", e.tag, k, obs(), e.v); else n_pass++;
            if (k < 7) serve_check("p1_point_serve", 4'(k), 1, 1'b1);
        end
        score_point(1'b1);
        expect_next("game_over_saturated", mk(ST_GAME_OVER, 7, 1, WIN_P1, 0, 1, 0, 0));
        step(1'b1, PAUSE_KEY, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
    endtask

    task automatic test_restart();
        expect_next("start_from_game_over", mk(ST_SERVE_WAIT, 0, 0, WIN_NONE, 0, 1, 1, 0));
        step(1'b1, START_KEY, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        serve_check("rematch_serve", 0, 0, 1'b1);
        score_point(1'b0); serve_check("rm_a", 0, 1, 1'b0);
        score_point(1'b0); serve_check("rm_b", 0, 2, 1'b0);
        score_point(1'b1); serve_check("rm_c", 1, 2, 1'b1);
        score_point(1'b1); serve_check("rm_d", 2, 2, 1'b1);
        expect_next("score_3_2", mk(ST_SERVE_WAIT, 3, 2, WIN_NONE, 0, 1, 1, 0));
        score_point(1'b1);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        expect_next("restart_mid_serve", mk(ST_IDLE, 0, 0, WIN_NONE, 0, 0, 1, 0));
        step(1'b1, RESTART_KEY, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        expect_next("idle_after_restart", mk(ST_IDLE, 0, 0, WIN_NONE, 0, 0, 0, 0));
        step(1'b0, 8'd0, 1'b1);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        step(1'b1, START_KEY, 1'b0);
        serve_check("serve_after_restart", 0, 0, 1'b0);
        // Asynchronous reset in PLAY clears outputs before any clock edge.
        expect_next("async_reset_in_play", 17'd0);
        #2 i_RST = 1'b1;
        #1;
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
        @(negedge i_CLK);
        i_RST = 1'b0;
        expect_next("idle_after_reset", mk(ST_IDLE, 0, 0, WIN_NONE, 0, 0, 0, 0));
        step(1'b0, 8'd0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %h, expected %h", e.tag, obs(), e.v); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_serve();
        test_p2_hold();
        test_pause();
        test_both();
        test_win();
        test_restart();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
